// File: rtl/lbus_initiator_if.sv
// Byte-wide local-bus initiator interface: command/response side
// plus lbus byte strobes; master = initiator, slave = host + device.
interface lbus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        lbus_rdy;
  logic [7:0]  lbus_wd;
  logic        lbus_we;
  logic        lbus_ful;
  logic [7:0]  lbus_rd;
  logic        lbus_re;
  logic        lbus_emp;

  modport master (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    input  lbus_rdy, lbus_ful,
    input  lbus_rd, lbus_emp,
    output cmd_ready, busy,
    output rsp_valid, rsp_rdata,
    output rsp_err,
    output lbus_wd, lbus_we,
    output lbus_re
  );

  modport slave (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    output lbus_rdy, lbus_ful,
    output lbus_rd, lbus_emp,
    input  cmd_ready, busy,
    input  rsp_valid, rsp_rdata,
    input  rsp_err,
    input  lbus_wd, lbus_we,
    input  lbus_re
  );
endinterface

// File: rtl/lbus_initiator.sv
// Local-bus initiator: serialises 16-bit register commands into
// the SAKURA-G byte protocol and returns one response per command.
// Ports: clock, resetn (async, active low), bus (master modport:
//   cmd_* request, rsp_* response, busy, lbus_* byte bus).
// LBUS_TIMEOUT_EN adds a wait-state watchdog of TIMEOUT_CYCLES.
module lbus_initiator #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             resetn,
  lbus_initiator_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_BYTE,
    WR_GAP,
    RD_WAIT,
    RD_PULSE,
    RD_CAP,
    RESP
  } state_t;

  state_t      state, state_d;
  logic [39:0] sreg, sreg_d;
  logic [2:0]  bcnt, bcnt_d;
  logic [1:0]  rcnt, rcnt_d;
  logic        is_wr, is_wr_d;
  logic [15:0] rdata, rdata_d;
  logic        run;

  logic [7:0]  wd, wd_d;
  logic        we, we_d;
  logic        re, re_d;
  logic        rvalid, rvalid_d;
  logic [15:0] rrdata, rrdata_d;
  logic        rerr, rerr_d;

  logic        accept;
  logic        tmo;

  // run keeps cmd_ready low while resetn is (or was just) low
  assign bus.cmd_ready = run && (state == IDLE)
                      && bus.lbus_rdy;
  assign accept = bus.cmd_ready && bus.cmd_valid;
  assign bus.busy = (state != IDLE);

  assign bus.lbus_wd   = wd;
  assign bus.lbus_we   = we;
  assign bus.lbus_re   = re;
  assign bus.rsp_valid = rvalid;
  assign bus.rsp_rdata = rrdata;
  assign bus.rsp_err   = rerr;

`ifdef LBUS_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wcnt, wcnt_d;
  logic          waiting;

  assign waiting =
    ((state == WR_BYTE) && bus.lbus_ful) ||
    ((state == RD_WAIT) && bus.lbus_emp);

  // fires on the edge where the count would reach the limit
  assign tmo = waiting &&
    (wcnt == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wcnt_d = wcnt;
    if (state_d != state)
      wcnt_d = '0;
    else if (waiting)
      wcnt_d = wcnt + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      wcnt <= '0;
    else
      wcnt <= wcnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    bcnt_d  = bcnt;
    rcnt_d  = rcnt;
    is_wr_d = is_wr;
    rdata_d = rdata;
    unique case (state)
      IDLE: begin
        if (accept) begin
          sreg_d  = {7'd0, bus.cmd_write,
                     bus.cmd_addr, bus.cmd_wdata};
          bcnt_d  = bus.cmd_write ? 3'd5 : 3'd3;
          is_wr_d = bus.cmd_write;
          rdata_d = '0;
          state_d = WR_BYTE;
        end
      end
      WR_BYTE: begin
        if (!bus.lbus_ful) begin
          sreg_d  = {sreg[31:0], 8'h00};
          bcnt_d  = bcnt - 3'd1;
          state_d = WR_GAP;
        end else if (tmo) begin
          state_d = RESP;
        end
      end
      WR_GAP: begin
        if (bcnt != 3'd0) begin
          state_d = WR_BYTE;
        end else if (is_wr) begin
          state_d = RESP;
        end else begin
          rcnt_d  = 2'd2;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!bus.lbus_emp)
          state_d = RD_PULSE;
        else if (tmo)
          state_d = RESP;
      end
      RD_PULSE: state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = {rdata[7:0], bus.lbus_rd};
        rcnt_d  = rcnt - 2'd1;
        state_d = (rcnt == 2'd1) ? RESP : RD_WAIT;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // strobes and response are registered from the
    // transition taken on this edge
    we_d     = (state == WR_BYTE) && !bus.lbus_ful;
    wd_d     = we_d ? sreg[39:32] : wd;
    re_d     = (state_d == RD_PULSE);
    rvalid_d = (state_d == RESP);
    rerr_d   = tmo;
    rrdata_d = (rvalid_d && !is_wr && !tmo)
             ? rdata_d : 16'h0000;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      sreg   <= '0;
      bcnt   <= '0;
      rcnt   <= '0;
      is_wr  <= 1'b0;
      rdata  <= '0;
      run    <= 1'b0;
      wd     <= '0;
      we     <= 1'b0;
      re     <= 1'b0;
      rvalid <= 1'b0;
      rrdata <= '0;
      rerr   <= 1'b0;
    end else begin
      state  <= state_d;
      sreg   <= sreg_d;
      bcnt   <= bcnt_d;
      rcnt   <= rcnt_d;
      is_wr  <= is_wr_d;
      rdata  <= rdata_d;
      run    <= 1'b1;
      wd     <= wd_d;
      we     <= we_d;
      re     <= re_d;
      rvalid <= rvalid_d;
      rrdata <= rrdata_d;
      rerr   <= rerr_d;
    end
  end

endmodule

// File: tb/tb_lbus_initiator.sv
// Directed bench for lbus_initiator: byte-stream model,
// per-cycle monitor, hand-computed cycle/data pins.
module tb_lbus_initiator;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  lbus_initiator_if bus();

  lbus_initiator #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  bit          active;
  int          acc_cyc;
  logic [7:0]  exp_bytes[$];
  logic [7:0]  dev_bytes[$];
  int          we_q[$];
  int          re_q[$];
  logic [15:0] exp_rdata;
  logic        exp_err;
  bit          rsp_seen;
  int          rsp_cyc;
  int          ful_from = -1, ful_to = -1;
  int          emp_from = -1, emp_to = -1;
  bit          emp_stuck = 1'b0;
  bit          prev_strobe;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h",
               name, act, exp);
    end
  endtask

  // per-cycle compare + device model
  always @(negedge clock) begin : mon
    int r;
    bit ok;
    if (resetn) begin
      r = cyc - acc_cyc;
      check("busy", 32'(bus.busy), 32'(active));
      check("we_re_overlap",
            32'(bus.lbus_we && bus.lbus_re), 0);
      check("strobe_spacing",
            32'(prev_strobe &&
                (bus.lbus_we || bus.lbus_re)), 0);
      prev_strobe = bus.lbus_we || bus.lbus_re;
      if (bus.lbus_we) begin
        ok = active && (exp_bytes.size() > 0);
        check("we_expected", 32'(ok), 1);
        if (ok) begin
          check("lbus_wd", 32'(bus.lbus_wd),
                32'(exp_bytes.pop_front()));
          we_q.push_back(r);
        end
      end
      if (bus.lbus_re) begin
        ok = active && (dev_bytes.size() > 0);
        check("re_expected", 32'(ok), 1);
        if (ok) begin
          bus.lbus_rd = dev_bytes.pop_front();
          re_q.push_back(r);
        end
      end
      if (bus.rsp_valid) begin
        check("rsp_expected", 32'(active), 1);
        if (active) begin
          check("rsp_rdata", 32'(bus.rsp_rdata),
                32'(exp_rdata));
          check("rsp_err", 32'(bus.rsp_err),
                32'(exp_err));
          rsp_cyc  = r;
          rsp_seen = 1'b1;
          active   = 1'b0;
        end
      end
      bus.lbus_ful = active && (r >= ful_from)
                  && (r < ful_to);
      bus.lbus_emp = emp_stuck ||
        (active && (r >= emp_from) && (r < emp_to));
    end
  end

  task automatic reset_checks();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_rsp_err",   32'(bus.rsp_err),   0);
    check("rst_busy",      32'(bus.busy),      0);
    check("rst_lbus_we",   32'(bus.lbus_we),   0);
    check("rst_lbus_re",   32'(bus.lbus_re),   0);
    check("rst_lbus_wd",   32'(bus.lbus_wd),   0);
  endtask

  // wr/a/d/rdw: command and device read word
  // fb/fl: ful held for fl cycles ahead of write byte fb
  // eb/el: emp held for el cycles ahead of read byte eb
  // hold: cycles with lbus_rdy low before acceptance
  // abort_n: reset after this many write strobes
  // lit: hand-computed rsp cycle; ee: expect timeout
  task automatic run_cmd(
    input bit wr, input logic [15:0] a,
    input logic [15:0] d, input logic [15:0] rdw,
    input int fb, input int fl,
    input int eb, input int el,
    input int hold, input int abort_n,
    input int lit, input bit ee);
    int n, w_last, m_rsp, k;
    int m_we[$];
    int m_re[$];
    bit got;
    n = wr ? 5 : 3;
    for (int i = 0; i < n; i++)
      m_we.push_back(2*i + 1 + ((i >= fb) ? fl : 0));
    w_last = m_we[n-1];
    if (!wr && !ee)
      for (int j = 0; j < 2; j++)
        m_re.push_back(w_last + 2 + 3*j
                       + ((j >= eb) ? el : 0));
    if (wr)      m_rsp = w_last + 1;
    else if (ee) m_rsp = w_last + 1 + 16;
    else         m_rsp = m_re[1] + 2;
    ful_from = (fl > 0) ? 2*fb : -1;
    ful_to   = (fl > 0) ? 2*fb + fl : -1;
    emp_from = (el > 0) ? w_last + 1 + 3*eb : -1;
    emp_to   = (el > 0) ? emp_from + el : -1;
    exp_rdata = (wr || ee) ? 16'h0000 : rdw;
    exp_err   = ee;
    we_q.delete();
    re_q.delete();
    rsp_seen = 1'b0;

    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    if (hold > 0) begin
      bus.lbus_rdy = 1'b0;
      for (int h = 0; h < hold; h++) begin
        #1;
        check("ready_gated", 32'(bus.cmd_ready), 0);
        @(negedge clock);
      end
      bus.lbus_rdy = 1'b1;
    end
    got = 1'b0;
    k = 0;
    while (k < 20 && !got) begin
      #1;
      if (bus.cmd_ready) got = 1'b1;
      else begin
        k++;
        @(negedge clock);
      end
    end
    check("accept_wait", 32'(k), 0);
    if (!got) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    active  = 1'b1;
    exp_bytes.push_back(wr ? 8'h01 : 8'h00);
    exp_bytes.push_back(a[15:8]);
    exp_bytes.push_back(a[7:0]);
    if (wr) begin
      exp_bytes.push_back(d[15:8]);
      exp_bytes.push_back(d[7:0]);
    end else if (!ee) begin
      dev_bytes.push_back(rdw[15:8]);
      dev_bytes.push_back(rdw[7:0]);
    end
    @(negedge clock);
    bus.cmd_valid = 1'b0;

    for (int t = 0; t < 300; t++) begin
      @(negedge clock);
      #2;
      if (abort_n > 0 && we_q.size() == abort_n) begin
        active = 1'b0;
        resetn = 1'b0;
        #1;
        reset_checks();
        exp_bytes.delete();
        dev_bytes.delete();
        prev_strobe = 1'b0;
        ful_from = -1; ful_to = -1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (6) @(negedge clock);
        #2;
        check("no_strobe_after_rst",
              32'(we_q.size() + re_q.size()),
              32'(abort_n));
        check("no_rsp_after_rst", 32'(rsp_seen), 0);
        return;
      end
      if (rsp_seen) break;
    end
    check("rsp_seen", 32'(rsp_seen), 1);
    if (rsp_seen) begin
      check("rsp_cycle", 32'(rsp_cyc), 32'(m_rsp));
      check("rsp_cycle_lit", 32'(rsp_cyc), 32'(lit));
      check("bytes_left", 32'(exp_bytes.size()), 0);
      check("we_count", 32'(we_q.size()), 32'(n));
      for (int i = 0; i < n && i < we_q.size(); i++)
        check("we_cycle", 32'(we_q[i]), 32'(m_we[i]));
      check("re_count", 32'(re_q.size()),
            32'(m_re.size()));
      for (int j = 0; j < m_re.size()
                      && j < re_q.size(); j++)
        check("re_cycle", 32'(re_q[j]), 32'(m_re[j]));
    end
    active = 1'b0;
    ful_from = -1; ful_to = -1;
    emp_from = -1; emp_to = -1;
    exp_bytes.delete();
    dev_bytes.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.lbus_rdy  = 1'b1;
    bus.lbus_ful  = 1'b0;
    bus.lbus_rd   = 8'h00;
    bus.lbus_emp  = 1'b0;
    active   = 1'b0;
    acc_cyc  = 0;
    prev_strobe = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    reset_checks();
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // write 0x0002 = 0x0001
    run_cmd(1, 16'h0002, 16'h0001, 16'h0000,
            0, 0, 0, 0, 0, 0, 10, 0);
    // read 0x0180 -> 0x1234
    run_cmd(0, 16'h0180, 16'h0000, 16'h1234,
            0, 0, 0, 0, 0, 0, 12, 0);
    // ful held 6 cycles ahead of byte 3
    run_cmd(1, 16'hA5C3, 16'h5A3C, 16'h0000,
            2, 6, 0, 0, 0, 0, 16, 0);
    // emp held 3 cycles ahead of 2nd read byte
    run_cmd(0, 16'hBEEF, 16'h0000, 16'hCAFE,
            0, 0, 1, 3, 0, 0, 15, 0);
    // lbus_rdy low for 5 cycles with cmd_valid up
    run_cmd(1, 16'h0010, 16'h0020, 16'h0000,
            0, 0, 0, 0, 5, 0, 10, 0);
    // reset after the 2nd write byte
    run_cmd(1, 16'h1234, 16'h5678, 16'h0000,
            0, 0, 0, 0, 0, 2, 0, 0);
    // read completes normally afterwards
    run_cmd(0, 16'h0042, 16'h0000, 16'h9A0B,
            0, 0, 0, 0, 0, 0, 12, 0);
`ifdef LBUS_TIMEOUT_EN
    // emp stuck: timeout 16 cycles into RD_WAIT
    emp_stuck = 1'b1;
    run_cmd(0, 16'h0003, 16'h0000, 16'h0000,
            0, 0, 0, 0, 0, 0, 22, 1);
    emp_stuck = 1'b0;
`endif
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/lbus_initiator.md
# lbus_initiator

Control-side local-bus initiator that drives the byte-wide SAKURA-G host bus into the main FPGA's host interface. It serialises 16-bit register write/read commands into the 5-byte write and 3+2-byte read byte protocol. It pulses lbus_we and lbus_re under the device's full/empty flow control and returns one response per command. It is used by the control FPGA and by the system bench to load masked shares, pulse start and read back s1/s2.

## Interface
- TIMEOUT_CYCLES, default 4096: wait-state watchdog limit in cycles; meaningful only with LBUS_TIMEOUT_EN.
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = register write, 0 = register read
- cmd_addr  in  16  register address
- cmd_wdata  in  16  write data; ignored for reads
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  16  read data; 0 for writes
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high from command acceptance through the rsp_valid cycle
- lbus_rdy  in  1  device ready
- lbus_wd  out  8  write byte
- lbus_we  out  1  write strobe, one cycle per byte
- lbus_ful  in  1  device cannot accept a byte
- lbus_rd  in  8  read byte
- lbus_re  out  1  read strobe, one cycle per byte
- lbus_emp  in  1  device has no byte to read

## Operation
- Byte streams, most significant byte first:
  - Write: 0x01, addr[15:8], addr[7:0], wdata[15:8], wdata[7:0].
  - Read: 0x00, addr[15:8], addr[7:0], then two bytes are read back, rdata[15:8] first.
- States: IDLE, WR_BYTE, WR_GAP, RD_WAIT, RD_PULSE, RD_CAP, RESP.
- IDLE:
  - cmd_ready = lbus_rdy.
  - On acceptance, latch cmd_write/addr/wdata into a 40-bit shift register, load the byte counter with 5 (write) or 3 (read), then go to WR_BYTE.
- WR_BYTE:
  - If lbus_ful = 0: lbus_we = 1 and lbus_wd = the top byte for exactly one cycle, shift the register, decrement the counter, then go to WR_GAP.
  - Otherwise hold with lbus_we = 0.
- WR_GAP: one mandatory idle cycle (lbus_we = 0). Then:
  - counter ≠ 0 → WR_BYTE;
  - counter = 0 and write → RESP;
  - counter = 0 and read → RD_WAIT, with the read counter set to 2.
- RD_WAIT: go to RD_PULSE when lbus_emp = 0.
- RD_PULSE: lbus_re = 1 for one cycle, then go to RD_CAP.
- RD_CAP: lbus_rd is sampled at the end of this cycle into rdata ({rdata[7:0], lbus_rd}). Then go to RD_WAIT, or to RESP after the 2nd byte.
- RESP: rsp_valid = 1 for one cycle, then return to IDLE. cmd_ready stays 0 in this cycle.
- lbus_rdy falling mid-command does not abort the command; it only gates acceptance in IDLE.
- All lbus_* outputs and rsp_* outputs are registered.

## Timing
- Reset values: cmd_ready 0, rsp_valid 0, rsp_rdata 0x0000, rsp_err 0, busy 0, lbus_we 0, lbus_re 0, lbus_wd 0x00. State returns to IDLE.
- Reset asserted mid-command: the command is abandoned with no response, and no strobe is emitted after resetn rises until a new command is accepted.
- Cycle 0 is the acceptance edge. With lbus_ful held 0, a write has:
  - lbus_we high in cycles 1, 3, 5, 7, 9;
  - rsp_valid in cycle 10.
- Read with lbus_ful and lbus_emp held 0:
  - lbus_we high in cycles 1, 3, 5;
  - lbus_re high in cycles 7 and 10;
  - rsp_valid in cycle 12.
- lbus_ful and lbus_emp are sampled one cycle before the corresponding strobe. Each cycle of lbus_ful = 1 (or lbus_emp = 1) extends latency by one cycle.
- lbus_we and lbus_re are never high together and never high in consecutive cycles.
- A new command can be accepted in the cycle after RESP, so back-to-back writes take 11 cycles each.

## Configuration
- LBUS_TIMEOUT_EN defined:
  - A wait counter clears on every state change and increments in WR_BYTE (while ful = 1) and in RD_WAIT.
  - When it reaches TIMEOUT_CYCLES, the block goes to RESP with rsp_err = 1 and rsp_rdata = 0x0000; the remaining bytes are dropped.
- LBUS_TIMEOUT_EN undefined: no counter, rsp_err is tied 0, and wait states hold indefinitely.

## Test plan
- Write 0x0002 = 0x0001 with ful = 0 → lbus_wd sequence 01,00,02,00,01 on we cycles 1, 3, 5, 7, 9; rsp_valid in cycle 10 with rsp_rdata 0x0000 and rsp_err 0.
- Read 0x0180 with emp = 0 and lbus_rd returning 0x12 then 0x34 → bytes 00,01,80 written; re in cycles 7 and 10; rsp_rdata 0x1234 in cycle 12.
- Write with lbus_ful held 1 for 6 cycles before byte 3 → byte 3 delayed exactly 6 cycles, sequence unchanged, rsp_valid in cycle 16.
- lbus_rdy = 0 with cmd_valid = 1 → cmd_ready 0 and no strobes; raising lbus_rdy → accepted on the next edge.
- resetn pulsed low after the 2nd write byte → all outputs at reset values, no further we/re; a following read completes normally.
- LBUS_TIMEOUT_EN with TIMEOUT_CYCLES = 16, read with lbus_emp stuck 1 → rsp_valid with rsp_err 1 and rdata 0x0000, 16 cycles after entering RD_WAIT.
